// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Frame: SYNC, LEN_HI, LEN_LO, payload (big-endian words), XOR checksum.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes MSB-first into M-bit words; word_valid fires
// combinationally together with the byte that completes a word.
module imem_loader_word_packer #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         word_valid,
  output logic [M-1:0] word
);

  localparam int BPW = M / 8;
  localparam int CW  = $clog2(BPW + 1);

  logic [CW-1:0] cnt;

  assign word_valid = byte_valid && (cnt == CW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (byte_valid) begin
      cnt <= word_valid ? '0 : cnt + 1'b1;
    end
  end

  // Only the first BPW-1 bytes need storing; the last one is used directly.
  if (M > 8) begin : g_multi
    logic [M-9:0] shreg;

    assign word = {shreg, byte_data};

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        shreg <= '0;
      end else if (byte_valid) begin
        shreg <= word[M-9:0];
      end
    end
  end else begin : g_single
    assign word = byte_data;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes words to instruction memory
// from address 0, and releases cpu_rst only after a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 32
) (
  input  logic         CLK,
  input  logic         RST,
  // Byte stream: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready is registered and never depends on in_valid.
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  output logic         cpu_rst,
  output logic         done,
  output logic         err,
  output state_t       dbg_state
);

  localparam int unsigned CAP = 2 ** N;

  state_t           state;
  logic [7:0]       len_hi;
  logic [7:0]       chk;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_now;
  logic [N:0]       addr;
  logic             accept;
  logic             sync_hit;
  logic             pk_valid;
  logic             word_valid;
  logic             last_word;
  logic [M-1:0]     word;

  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign sync_hit  = accept && ((state == IDLE) || (state == DONE)) && (in_data == SYNC_BYTE);
  assign pk_valid  = accept && (state == DATA);
  assign len_now   = {len_hi, in_data};
  // The counter is one bit wider than the address so L = 2^N ends without wrapping.
  assign last_word = (LEN_W'(addr) + LEN_W'(1)) == len;

  imem_loader_word_packer #(.M(M)) u_word_packer (
    .clk        (CLK),
    .rst        (RST),
    .clear      (sync_hit),
    .byte_valid (pk_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      len_hi    <= '0;
      len       <= '0;
      chk       <= '0;
      addr      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      if (sync_hit) begin
        state   <= LEN_HI;
        cpu_rst <= 1'b1;
        done    <= 1'b0;
        chk     <= '0;
        addr    <= '0;
      end else if (accept) begin
        case (state)
          LEN_HI: begin
            len_hi <= in_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            len <= len_now;
            if (32'(len_now) > CAP) begin
              state    <= ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end else if (len_now == '0) begin
              state <= CHK;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            chk <= chk ^ in_data;
            if (word_valid) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr[N-1:0];
              mem_wdata <= word;
              addr      <= addr + 1'b1;
              if (last_word) state <= CHK;
            end
          end
          CHK: begin
            if (in_data == chk) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state    <= ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
      // ERR is only left through RST; the stream stays blocked meanwhile.
      if (state == ERR) in_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word lists by a
// reference model that also predicts every memory write and the final status.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int N   = 5;
  localparam int M   = 32;
  localparam int BPW = M / 8;
  localparam int W   = N + M;
  localparam int CAP = 2 ** N;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [M-1:0] mem_wdata;
  logic         cpu_rst;
  logic         done;
  logic         err;
  state_t       dbg_state;

  int n_pass   = 0;
  int n_total  = 0;
  int n_writes = 0;

  logic [W-1:0] exp_q[$];
  logic [M-1:0] words_q[$];
  logic [7:0]   frame_q[$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_want;

  imem_loader #(.N(N), .M(M)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard: every write must match the next expected one ----------------
  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      n_total++;
      mon_got = {mem_addr, mem_wdata};
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want)
          $display("FAIL write_match: got addr=%0d data=%h, required addr=%0d data=%h",
                   mon_got[W-1:M], mon_got[M-1:0], mon_want[W-1:M], mon_want[M-1:0]);
        else
          n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int budget;
    while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge CLK);
    end
    in_valid = 1'b1;
    in_data  = b;
    budget   = 50;
    while (in_ready !== 1'b1 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (budget == 0) begin
      n_total++;
      $display("FAIL in_ready_timeout: got in_ready=%b for 50 cycles, required 1", in_ready);
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic fill_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom());
  endtask

  // Reference model: frame bytes from words_q, checksum = XOR of payload,
  // and one expected write per word at consecutive addresses from 0.
  task automatic build_frame(input logic [7:0] flip);
    logic [7:0] x;
    logic [15:0] l;
    x = 8'h00;
    l = 16'(words_q.size());
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(l[15:8]);
    frame_q.push_back(l[7:0]);
    foreach (words_q[i]) begin
      for (int b = BPW - 1; b >= 0; b--) begin
        frame_q.push_back(words_q[i][8*b +: 8]);
        x = x ^ words_q[i][8*b +: 8];
      end
    end
    frame_q.push_back(x ^ flip);
    foreach (words_q[i]) exp_q.push_back({N'(i), words_q[i]});
  endtask

  task automatic send_frame(input int gap_pct);
    foreach (frame_q[i]) send_byte(frame_q[i], gap_pct);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    pulse_reset();
    n_total++;
    if ({cpu_rst, in_ready, mem_we, done, err, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {N{1'b0}}, {M{1'b0}}})
      $display("FAIL reset_values: got cpu_rst=%b in_ready=%b we=%b done=%b err=%b addr=%0d wdata=%h, required 1 0 0 0 0 0 0",
               cpu_rst, in_ready, mem_we, done, err, mem_addr, mem_wdata);
    else n_pass++;
    n_total++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d, required IDLE", dbg_state);
    else n_pass++;
    RST = 1'b0;
    @(negedge CLK);
    n_total++;
    if ({in_ready, cpu_rst, done, err} !== 4'b1100)
      $display("FAIL reset_release: got in_ready=%b cpu_rst=%b done=%b err=%b, required 1 1 0 0",
               in_ready, cpu_rst, done, err);
    else n_pass++;
  endtask

  task automatic test_basic();
    int w0;
    w0 = n_writes;
    words_q.delete();
    words_q.push_back(32'h11223344);
    words_q.push_back(32'hAABBCCDD);
    build_frame(8'h00);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], 0);
      if (i == 6) begin
        n_total++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, {N{1'b0}}, 32'h11223344})
          $display("FAIL basic_write_latency: got we=%b addr=%0d data=%h, required 1 0 11223344",
                   mem_we, mem_addr, mem_wdata);
        else n_pass++;
      end
    end
    n_total++;
    if ({done, cpu_rst, err} !== 3'b100)
      $display("FAIL basic_done: got done=%b cpu_rst=%b err=%b, required 1 0 0", done, cpu_rst, err);
    else n_pass++;
    n_total++;
    if (n_writes - w0 != 2 || exp_q.size() != 0)
      $display("FAIL basic_write_count: got %0d writes (%0d pending), required 2 (0)", n_writes - w0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    int w0;
    w0 = n_writes;
    words_q.delete();
    words_q.push_back(32'h11223344);
    words_q.push_back(32'hAABBCCDD);
    build_frame(8'h00);
    frame_q[frame_q.size() - 1] = frame_q[frame_q.size() - 1] ^ 8'h45;
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], 0);
      if (i == 0) begin
        n_total++;
        if ({done, cpu_rst} !== 2'b01)
          $display("FAIL resync_clears_done: got done=%b cpu_rst=%b, required 0 1", done, cpu_rst);
        else n_pass++;
      end
    end
    n_total++;
    if ({err, cpu_rst, in_ready, done} !== 4'b1100)
      $display("FAIL badchk_err: got err=%b cpu_rst=%b in_ready=%b done=%b, required 1 1 0 0",
               err, cpu_rst, in_ready, done);
    else n_pass++;
    n_total++;
    if (n_writes - w0 != 2)
      $display("FAIL badchk_writes_kept: got %0d writes, required 2", n_writes - w0);
    else n_pass++;
    pulse_reset();
    RST = 1'b0;
    @(negedge CLK);
    n_total++;
    if ({err, cpu_rst, in_ready, dbg_state} !== {3'b011, IDLE})
      $display("FAIL badchk_reset_clears: got err=%b cpu_rst=%b in_ready=%b state=%0d, required 0 1 1 IDLE",
               err, cpu_rst, in_ready, dbg_state);
    else n_pass++;
  endtask

  task automatic test_empty();
    int w0;
    logic [7:0] bytes [6];
    w0 = n_writes;
    bytes = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i], 0);
      if (i == 1) begin
        n_total++;
        if (dbg_state !== IDLE) $display("FAIL empty_drop: got state=%0d, required IDLE", dbg_state);
        else n_pass++;
      end
    end
    repeat (2) @(negedge CLK);
    n_total++;
    if ({done, cpu_rst, err, dbg_state} !== {3'b100, DONE} || n_writes != w0)
      $display("FAIL empty_frame: got done=%b cpu_rst=%b err=%b state=%0d writes=%0d, required 1 0 0 DONE 0",
               done, cpu_rst, err, dbg_state, n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_too_long();
    int w0;
    w0 = n_writes;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'(CAP + 1), 0);
    n_total++;
    if ({err, in_ready, cpu_rst} !== 3'b101 || n_writes != w0)
      $display("FAIL too_long: got err=%b in_ready=%b cpu_rst=%b writes=%0d, required 1 0 1 0",
               err, in_ready, cpu_rst, n_writes - w0);
    else n_pass++;
    pulse_reset();
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_full();
    int w0;
    w0 = n_writes;
    fill_words(CAP);
    build_frame(8'h00);
    send_frame(30);
    repeat (3) @(negedge CLK);
    n_total++;
    if ({done, cpu_rst, err} !== 3'b100 || n_writes - w0 != CAP || exp_q.size() != 0)
      $display("FAIL full_frame: got done=%b cpu_rst=%b err=%b writes=%0d pending=%0d, required 1 0 0 %0d 0",
               done, cpu_rst, err, n_writes - w0, exp_q.size(), CAP);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int w0;
    w0 = n_writes;
    fill_words(2);
    build_frame(8'h00);
    void'(exp_q.pop_back());
    for (int i = 0; i < 3 + 6; i++) send_byte(frame_q[i], 0);
    n_total++;
    if (n_writes - w0 != 1) $display("FAIL midrst_partial: got %0d writes, required 1", n_writes - w0);
    else n_pass++;
    pulse_reset();
    n_total++;
    if ({cpu_rst, in_ready, mem_we, done, err, mem_addr, mem_wdata, dbg_state} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {N{1'b0}}, {M{1'b0}}, IDLE})
      $display("FAIL midrst_values: got cpu_rst=%b in_ready=%b we=%b done=%b err=%b addr=%0d wdata=%h state=%0d, required reset values",
               cpu_rst, in_ready, mem_we, done, err, mem_addr, mem_wdata, dbg_state);
    else n_pass++;
    RST = 1'b0;
    @(negedge CLK);
    w0 = n_writes;
    fill_words(CAP);
    build_frame(8'h00);
    send_frame(20);
    repeat (3) @(negedge CLK);
    n_total++;
    if ({done, cpu_rst} !== 2'b10 || n_writes - w0 != CAP || exp_q.size() != 0)
      $display("FAIL midrst_reload: got done=%b cpu_rst=%b writes=%0d pending=%0d, required 1 0 %0d 0",
               done, cpu_rst, n_writes - w0, exp_q.size(), CAP);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w0;
    int l;
    logic [7:0] flip;
    for (int f = 0; f < 5; f++) begin
      w0   = n_writes;
      l    = int'($urandom_range(CAP, 0));
      flip = (f == 4) ? 8'($urandom_range(255, 1)) : 8'h00;
      fill_words(l);
      build_frame(flip);
      send_frame((f % 2 == 0) ? 0 : 25);
      repeat (2) @(negedge CLK);
      n_total++;
      if ({done, err, cpu_rst} !== ((flip == 8'h00) ? 3'b100 : 3'b011) || n_writes - w0 != l)
        $display("FAIL b2b_frame%0d: got done=%b err=%b cpu_rst=%b writes=%0d, required flip=%h writes=%0d",
                 f, done, err, cpu_rst, n_writes - w0, flip, l);
      else n_pass++;
    end
    pulse_reset();
    RST = 1'b0;
    @(negedge CLK);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_empty();
    test_too_long();
    test_full();
    test_mid_reset();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL final_pending: got %0d pending writes, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
